// File: rtl/demux_1xn_stream.sv
// Registered 1-to-N stream demultiplexer with per-channel valid/ready and a round-robin mode.
// Optional sticky out-of-range select flag enabled by defining DEMUX_SEL_ERR_EN.

module demux_1xn_stream_lane #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] ld_data,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid
);
    // A load on the same edge as a drain keeps the slot full: full throughput.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (load) begin
            out_valid <= 1'b1;
            out_data  <= ld_data;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end
endmodule

module demux_1xn_stream #(
    parameter int WIDTH = 8,
    parameter int N     = 4,
    parameter int SELW  = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               mode,
    input  logic [WIDTH-1:0]   in_data,
    input  logic [SELW-1:0]    in_sel,
    input  logic               in_valid,
    output logic               in_ready,
    output logic [N*WIDTH-1:0] out_data,
    output logic [N-1:0]       out_valid,
    input  logic [N-1:0]       out_ready,
    output logic [SELW-1:0]    rr_ptr,
    output logic               busy
`ifdef DEMUX_SEL_ERR_EN
    ,
    output logic               sel_err
`endif
);
    logic [SELW-1:0] tgt;
    logic [N-1:0]    load;
    logic            tgt_rdy;
    logic            accept;

    assign tgt = mode ? rr_ptr : in_sel;

    // A target with no matching lane is out of range: always ready, nothing loaded.
    always_comb begin
        tgt_rdy = 1'b1;
        for (int k = 0; k < N; k++) begin
            if (tgt == SELW'(k)) tgt_rdy = ~out_valid[k] | out_ready[k];
        end
    end

    assign in_ready = tgt_rdy;
    assign accept   = in_valid & tgt_rdy;
    assign busy     = |out_valid;

    for (genvar k = 0; k < N; k++) begin : g_lane
        assign load[k] = accept & (tgt == SELW'(k));

        demux_1xn_stream_lane #(.WIDTH(WIDTH)) u_lane (
            .clk       (clk),
            .rst_n     (rst_n),
            .load      (load[k]),
            .ld_data   (in_data),
            .out_ready (out_ready[k]),
            .out_data  (out_data[k*WIDTH +: WIDTH]),
            .out_valid (out_valid[k])
        );
    end

    always_ff @(posedge clk) begin
        if (!rst_n)
            rr_ptr <= '0;
        else if (accept & mode)
            rr_ptr <= (rr_ptr == SELW'(N-1)) ? '0 : rr_ptr + SELW'(1);
    end

`ifdef DEMUX_SEL_ERR_EN
    // Accepted but no lane loaded means the select was out of range.
    always_ff @(posedge clk) begin
        if (!rst_n)
            sel_err <= 1'b0;
        else if (accept & ~|load)
            sel_err <= 1'b1;
    end
`endif
endmodule

// File: doc/demux_1xn_stream.md
Name: demux_1xn_stream

Overview:
- Parametrised, registered 1-to-N demultiplexer for WIDTH-bit data with a valid/ready handshake on the input and on every output channel.
- Successor to the team's combinational 2x1 demux primitive. Adds channel count, data width, output buffering, backpressure and a round-robin distribution mode.
- Sits between a single producer and N consumers, such as gate-array test lanes or parallel result sinks.

Parameters:
- WIDTH, 8, data bits per transfer.
- N, 4, number of output channels (2..16).
- SELW, 2, select width; must satisfy 2**SELW >= N.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous active-low reset.
- mode  input  1  0 = explicit select via in_sel; 1 = round-robin.
- in_data  input  WIDTH  input payload.
- in_sel  input  SELW  target channel; used only when mode=0.
- in_valid  input  1  input payload valid.
- in_ready  output  1  block can accept the input this cycle.
- out_data  output  N*WIDTH  channel k occupies bits [k*WIDTH +: WIDTH].
- out_valid  output  N  per-channel valid.
- out_ready  input  N  per-channel consumer ready.
- rr_ptr  output  SELW  next round-robin target channel.
- busy  output  1  OR of out_valid.

Behaviour:
- Reset: on rst_n=0 at a clk edge, the following clear on that edge:
  - out_valid=0, out_data=0, rr_ptr=0.
  - busy=0. busy is derived from out_valid, so it falls with it.
  - sel_err=0, when the optional feature is compiled in.
- Reset mid-transfer discards any buffered data. No output handshake completes in the reset cycle.
- Target channel t:
  - mode=0: t=in_sel.
  - mode=1: t=rr_ptr.
  - Evaluated combinationally each cycle.
- Out-of-range select: in_sel >= N with mode=0.
  - in_ready=1.
  - The transfer is accepted and dropped; no out_valid is set.
- In-range select: in_ready = ~out_valid[t] | out_ready[t]. This is combinational from out_ready, mode, in_sel and rr_ptr.
- Input accept: in_valid & in_ready at the clk edge.
  - out_data[t] <= in_data and out_valid[t] <= 1 on that edge.
  - Latency: 1 cycle, input accept to out_valid high.
- Output handshake: on out_valid[k] & out_ready[k], out_valid[k] clears at the edge, unless the same edge also accepts new data into k. In that case out_valid[k] stays 1 and out_data[k] takes the new word. This is the full-throughput case.
- Holding: out_data[k] is stable while out_valid[k]=1 and out_ready[k]=0.
- Per-channel independence: a stalled channel blocks only transfers targeting it. Other channels continue to drain on their own out_ready.
- Round-robin pointer:
  - Advances only on an accepted transfer while mode=1: rr_ptr <= (rr_ptr==N-1) ? 0 : rr_ptr+1.
  - Wraps N-1 to 0; values >= N never occur.
  - Held unchanged while mode=0.
- Mode change: takes effect in the same cycle.
  - Data already buffered is unaffected.
  - Switching back to mode=1 resumes from the held rr_ptr.
- No skipping in round-robin: if channel rr_ptr is full and not draining, in_ready=0 and the block waits. It never skips to another channel, so the distribution order is strict.
- in_valid low: no state change other than output drains.

Optional Feature:
- Macro: DEMUX_SEL_ERR_EN.
- Defined:
  - Adds output port sel_err (1 bit).
  - sel_err goes high on the edge that accepts an out-of-range transfer (mode=0, in_sel>=N, in_valid=1).
  - sel_err is sticky until rst_n=0.
- Undefined:
  - Port sel_err is absent.
  - Out-of-range transfers are dropped silently.
  - All other behaviour is identical.

Test Plan:
1. Reset: hold rst_n=0 for 2 cycles with in_valid=1, in_sel=2, mode=0 -> out_valid=0, out_data=0, rr_ptr=0, busy=0 throughout; no capture.
2. Explicit routing: N=4, WIDTH=8, out_ready=4'b1111; send 0xA1 to sel 0, 0xB2 to sel 1, 0xC3 to sel 2, 0xD4 to sel 3 on consecutive cycles -> each out_valid[k] pulses for one cycle, one cycle after its input, with the matching byte; in_ready stays 1.
3. Backpressure: out_ready[1]=0; send 0x11 then 0x22 to sel 1 -> 0x11 held on channel 1 and in_ready=0 on the second word; meanwhile 0x33 to sel 3 is accepted. Raise out_ready[1] -> 0x22 is accepted in the same cycle and appears next cycle.
4. Round-robin wrap: mode=1, all ready; send 6 words 0x01..0x06 -> they land on channels 0,1,2,3,0,1; rr_ptr ends at 2. Set mode=0, send 1 word, set mode=1 -> rr_ptr still 2.
5. Round-robin stall: mode=1, rr_ptr=1, out_valid[1]=1, out_ready[1]=0 -> in_ready=0 and no channel is written, although channels 0, 2 and 3 are empty.
6. Out-of-range (N=3, SELW=2, DEMUX_SEL_ERR_EN defined): send in_sel=3 with data 0xFF -> accepted with in_ready=1, no out_valid, sel_err=1 the next cycle and sticky until reset.
